// File: rtl/aes_pkg.sv
// Shared AES constants and helpers: S-box table, round constants,
// key-schedule FSM state type and the legal key-length/round pairings.
package aes_pkg;

    // Columns per state block; a round key is NB 32-bit words.
    localparam int NB = 4;

    // Forward S-box, byte x stored at bits [2047-8x -: 8].
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_t;

    // Single-byte S-box lookup.
    function automatic logic [7:0] sbox_byte(input logic [7:0] x);
        int idx;
        idx = 2047 - 8 * int'(x);
        return SBOX_TABLE[idx -: 8];
    endfunction

    // SubWord: S-box applied to each byte of a word.
    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_byte(w[31:24]), sbox_byte(w[23:16]),
                sbox_byte(w[15:8]),  sbox_byte(w[7:0])};
    endfunction

    // Round constant high byte for schedule step n (1-based).
    function automatic logic [7:0] rcon(input logic [5:0] n);
        logic [7:0] r;
        case (n)
            6'd1:    r = 8'h01;
            6'd2:    r = 8'h02;
            6'd3:    r = 8'h04;
            6'd4:    r = 8'h08;
            6'd5:    r = 8'h10;
            6'd6:    r = 8'h20;
            6'd7:    r = 8'h40;
            6'd8:    r = 8'h80;
            6'd9:    r = 8'h1b;
            6'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // AES-128/192/256 are the only supported key/round combinations.
    function automatic bit nk_nr_legal(input int nk, input int nr);
        return ((nk == 4) && (nr == 10)) ||
               ((nk == 6) && (nr == 12)) ||
               ((nk == 8) && (nr == 14));
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES S-box, shared by the key schedule and round engines.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] subst
);

    assign subst = sbox_byte(data);

endmodule

// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion: one expanded word per clock into a round-key
// store, served through a registered indexed read port and a flat bus.
module key_schedule_seq
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NK*32-1:0]          key_in,
    input  logic                      key_load,
    output logic                      busy,
    output logic                      keys_valid,
    input  logic [3:0]                rd_round,
    output logic [127:0]              rd_key,
    output logic [0:(NR+1)*128-1]     w_all
);

    localparam int         NW     = NB * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [3:0] NR_W   = 4'(NR);

    ks_state_t   state;
    logic [5:0]  cnt;
    logic [31:0] store [0:NW-1];

    logic [5:0]  phase;
    logic [5:0]  rc_idx;
    logic [5:0]  prev_idx;
    logic [5:0]  old_idx;
    logic [31:0] prev_word;
    logic [31:0] old_word;
    logic [31:0] sbox_in;
    logic [31:0] sbox_out;
    logic [31:0] temp_word;
    logic [31:0] next_word;
    logic [5:0]  rd_base;

    // Next schedule word w[cnt] from w[cnt-1] and w[cnt-NK].
    always_comb begin
        phase  = cnt % NK_W;
        rc_idx = cnt / NK_W;
        if (cnt == 6'd0) begin
            prev_idx = 6'd0;
        end else begin
            prev_idx = cnt - 6'd1;
        end
        if (cnt >= NK_W) begin
            old_idx = cnt - NK_W;
        end else begin
            old_idx = 6'd0;
        end
        prev_word = store[prev_idx];
        old_word  = store[old_idx];
        if (phase == 6'd0) begin
            sbox_in = {prev_word[23:0], prev_word[31:24]};
        end else begin
            sbox_in = prev_word;
        end
        if (phase == 6'd0) begin
            temp_word = sbox_out ^ {rcon(rc_idx), 24'h000000};
        end else if ((NK == 8) && (phase == 6'd4)) begin
            temp_word = sbox_out;
        end else begin
            temp_word = prev_word;
        end
        next_word = old_word ^ temp_word;
    end

    // Four byte lanes of SubWord.
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .data  (sbox_in[g*8 +: 8]),
            .subst (sbox_out[g*8 +: 8])
        );
    end

    // Expansion FSM: load, per-cycle word generation, completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 6'd0;
            busy       <= 1'b0;
            keys_valid <= 1'b0;
            for (int j = 0; j < NW; j++) begin
                store[j] <= 32'h0000_0000;
            end
        end else if (key_load) begin
            // A load restarts from scratch, even mid-expansion.
            for (int j = 0; j < NK; j++) begin
                store[j] <= key_in[(NK-1-j)*32 +: 32];
            end
            cnt        <= NK_W;
            busy       <= 1'b1;
            keys_valid <= 1'b0;
            state      <= ST_EXPAND;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end
                ST_EXPAND: begin
                    store[cnt] <= next_word;
                    if (cnt == LAST_W) begin
                        // Counter parks on the last index.
                        state      <= ST_DONE;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state      <= ST_IDLE;
                    busy       <= 1'b0;
                    keys_valid <= 1'b0;
                end
            endcase
        end
    end

    // Base word index of the requested round.
    always_comb begin
        rd_base = {rd_round, 2'b00};
    end

    // Registered round-key read; zero unless the schedule is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key <= 128'd0;
        end else if (!keys_valid || (rd_round > NR_W)) begin
            rd_key <= 128'd0;
        end else begin
            rd_key <= {store[rd_base], store[rd_base | 6'd1],
                       store[rd_base | 6'd2], store[rd_base | 6'd3]};
        end
    end

    // Flat view of the store, round 0 at the low (MSB-first) end.
    for (genvar r = 0; r <= NR; r++) begin : g_wall
        assign w_all[r*128 +: 128] = {store[4*r], store[4*r+1],
                                      store[4*r+2], store[4*r+3]};
    end

endmodule

// File: tb/tb_key_schedule_seq.sv
// Self-checking bench for key_schedule_seq at AES-128/192/256 against an
// S-box derived from GF(2^8) inversion and a word-array key expansion.
module tb_key_schedule_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] key;
    logic         load4, load6, load8;
    logic [3:0]   rd_round;

    logic busy4, busy6, busy8, valid4, valid6, valid8;
    logic [127:0] rd4, rd6, rd8;
    logic [0:1407] w4;
    logic [0:1663] w6;
    logic [0:1919] w8;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  sbox_ref [0:255];
    logic [7:0]  rc_tab   [0:10];
    logic [31:0] mw       [0:59];

    always #5 clk = ~clk;

    key_schedule_seq #(.NK(4), .NR(10)) dut4 (
        .clk(clk), .rst(rst), .key_in(key[255:128]), .key_load(load4),
        .busy(busy4), .keys_valid(valid4), .rd_round(rd_round),
        .rd_key(rd4), .w_all(w4));
    key_schedule_seq #(.NK(6), .NR(12)) dut6 (
        .clk(clk), .rst(rst), .key_in(key[255:64]), .key_load(load6),
        .busy(busy6), .keys_valid(valid6), .rd_round(rd_round),
        .rd_key(rd6), .w_all(w6));
    key_schedule_seq #(.NK(8), .NR(14)) dut8 (
        .clk(clk), .rst(rst), .key_in(key), .key_load(load8),
        .busy(busy8), .keys_valid(valid8), .rd_round(rd_round),
        .rd_key(rd8), .w_all(w8));

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int n = 0; n < 8; n++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv, base;
        int e;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            base = 8'(x);
            e = 254;
            while (e > 0) begin
                if (e % 2 == 1) inv = gmul(inv, base);
                base = gmul(base, base);
                e = e / 2;
            end
            if (x == 0) inv = 8'h00;
            sbox_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                          ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc_tab[0] = 8'h00;
        rc_tab[1] = 8'h01;
        for (int j = 2; j <= 10; j++) rc_tab[j] = gmul(rc_tab[j-1], 8'h02);
    endtask

    function automatic logic [31:0] sub_ref(input logic [31:0] t);
        return {sbox_ref[t[31:24]], sbox_ref[t[23:16]],
                sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input logic [255:0] k);
        int nw;
        logic [31:0] t;
        nw = 4 * (nk + 7);
        for (int j = 0; j < nk; j++) mw[j] = k[255 - 32*j -: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t = sub_ref({t[23:0], t[31:24]}) ^ {rc_tab[i/nk], 24'h000000};
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_ref(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] model_round(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    function automatic logic dut_valid(input int nk);
        return (nk == 4) ? valid4 : (nk == 6) ? valid6 : valid8;
    endfunction

    function automatic logic dut_busy(input int nk);
        return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
    endfunction

    function automatic logic [127:0] dut_rd(input int nk);
        return (nk == 4) ? rd4 : (nk == 6) ? rd6 : rd8;
    endfunction

    function automatic logic [127:0] dut_round(input int nk, input int r);
        if (nk == 4) return w4[r*128 +: 128];
        else if (nk == 6) return w6[r*128 +: 128];
        else return w8[r*128 +: 128];
    endfunction

    task automatic set_load(input int nk, input logic v);
        if (nk == 4) load4 = v;
        else if (nk == 6) load6 = v;
        else load8 = v;
    endtask

    // Drives key_load for exactly one edge; returns 1 time unit after it.
    task automatic do_load(input int nk, input logic [255:0] k);
        key = k;
        set_load(nk, 1'b1);
        @(posedge clk); #1;
        set_load(nk, 1'b0);
    endtask

    task automatic run_check(input int nk, input logic [255:0] k, input string name);
        int edges, nr, rr;
        nr = nk + 6;
        model_expand(nk, k);
        rd_round = 4'd0;
        do_load(nk, k);
        check_eq({name, "_busy_after_load"}, 128'(dut_busy(nk)), 128'd1);
        check_eq({name, "_valid_after_load"}, 128'(dut_valid(nk)), 128'd0);
        edges = 1;
        while (!dut_valid(nk) && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        check_eq({name, "_latency"}, 128'(edges), 128'(4 * (nr + 1) - nk + 1));
        check_eq({name, "_rd_on_valid_edge"}, dut_rd(nk), 128'd0);
        check_eq({name, "_busy_done"}, 128'(dut_busy(nk)), 128'd0);
        for (int r = 0; r <= nr; r++) begin
            check_eq($sformatf("%s_wall_r%0d", name, r), dut_round(nk, r), model_round(r));
        end
        @(posedge clk); #1;
        check_eq({name, "_rd_r0"}, dut_rd(nk), model_round(0));
        rr = $urandom_range(nr, 1);
        rd_round = 4'(rr);
        @(posedge clk); #1;
        check_eq($sformatf("%s_rd_r%0d", name, rr), dut_rd(nk), model_round(rr));
        rd_round = 4'(nr + 1);
        @(posedge clk); #1;
        check_eq({name, "_rd_out_of_range"}, dut_rd(nk), 128'd0);
    endtask

    initial begin
        logic [255:0] ka, kb, kr;
        rst = 1'b1; load4 = 1'b0; load6 = 1'b0; load8 = 1'b0;
        key = 256'd0; rd_round = 4'd0;
        build_tables();
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_busy", 128'({busy4, busy6, busy8}), 128'd0);
        check_eq("reset_valid", 128'({valid4, valid6, valid8}), 128'd0);
        check_eq("reset_wall4", w4[0:127], 128'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // FIPS-197 AES-128 example.
        ka = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0};
        run_check(4, ka, "aes128_a");
        check_eq("aes128_a_r10_const", dut_round(4, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check_eq("aes128_a_r0_key", dut_round(4, 0), ka[255:128]);

        kb = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
        run_check(4, kb, "aes128_b");
        check_eq("aes128_b_r10_const", dut_round(4, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // FIPS-197 AES-256 example; also moves key_in under the idle AES-128 unit.
        kr = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        run_check(8, kr, "aes256");
        check_eq("aes256_r14_const", dut_round(8, 14), 128'hfe4890d1e6188d0b046df344706c631e);
        check_eq("key_change_no_effect", dut_round(4, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

        kr = {128'h8e73b0f7da0e6452c810f32b809079e5, 64'h62f8ead2522c6b7b, 64'd0};
        run_check(6, kr, "aes192");

        // Randomised keys for every key length.
        for (int it = 0; it < 3; it++) begin
            kr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            run_check(4, kr, $sformatf("rand128_%0d", it));
            run_check(6, kr, $sformatf("rand192_%0d", it));
            run_check(8, kr, $sformatf("rand256_%0d", it));
        end

        // Abort: reload with a new key on the 20th edge of a running expansion.
        ka = {$urandom, $urandom, $urandom, $urandom, 128'd0};
        kb = {$urandom, $urandom, $urandom, $urandom, 128'd0};
        do_load(4, ka);
        for (int n = 2; n < 20; n++) begin
            @(posedge clk); #1;
            check_eq($sformatf("abort_valid_e%0d", n), 128'(valid4), 128'd0);
        end
        run_check(4, kb, "abort_b");

        // Reset from DONE with a live read: store, read port and flags all clear.
        rd_round = 4'd3;
        @(posedge clk); #1;
        check_eq("pre_rst_rd3", rd4, model_round(3));
        rst = 1'b1; load4 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load4 = 1'b0;
        check_eq("rst_done_rd", rd4, 128'd0);
        check_eq("rst_done_valid", 128'(valid4), 128'd0);
        check_eq("rst_done_wall", 128'(|w4), 128'd0);

        // Reset together with key_load mid-expansion on the AES-256 unit.
        do_load(8, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_busy", 128'(busy8), 128'd1);
        rst = 1'b1; load8 = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; load8 = 1'b0;
        check_eq("rst_mid_busy", 128'(busy8), 128'd0);
        check_eq("rst_mid_valid", 128'(valid8), 128'd0);
        check_eq("rst_mid_rd", rd8, 128'd0);
        check_eq("rst_mid_wall", 128'(|w8), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_stays_idle", 128'(busy8), 128'd0);

        // Recovery after reset.
        run_check(8, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
